// File: rtl/apb_reg_slave.sv
// APB register slave: NumRegs x 32-bit register file behind an APB port.
// Register 0 is a read-only ID word, registers 1..NumRegs-1 are read/write.
// Every transfer passes through a fixed number of wait states; setup-phase
// address, direction and write data are latched and used for the rest of it.
module apb_reg_slave #(
  parameter int NumRegs    = 8,
  parameter int WaitStates = 1
) (
  input  logic                   a_clk,
  input  logic                   a_reset,
  input  logic [31:0]            p_addr,
  input  logic                   p_sel,
  input  logic                   p_enable,
  input  logic                   p_write,
  input  logic [31:0]            p_wdata,
  output logic [31:0]            p_rdata,
  output logic                   p_ready,
  output logic                   p_slverr,
  output logic [NumRegs*32-1:0]  reg_q,
  output logic [NumRegs-1:0]     wr_pulse
);

  localparam int                 IdxW     = $clog2(NumRegs);
  localparam logic [31:0]        IdValue  = 32'hA9B0_0001;
  localparam logic [3:0]         WaitLoad = 4'(WaitStates);
  localparam logic               NoWait   = (WaitStates == 0);
  localparam logic [NumRegs-1:0] OneHot0  = {{(NumRegs-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      next_state_s;
  logic                        setup_s;
  logic [3:0]                  cnt_r;
  logic [31:0]                 addr_r;
  logic [31:0]                 wdata_r;
  logic                        write_r;
  logic [NumRegs-1:1][31:0]    regs_r;

  logic [31:0]                 cur_addr_s;
  logic                        cur_write_s;
  logic [IdxW-1:0]             cur_idx_s;
  logic                        cur_valid_s;
  logic                        cur_err_s;
  logic [31:0]                 rd_word_s;
  logic [IdxW-1:0]             wr_idx_s;
  logic                        enter_access_s;
  logic                        commit_s;

  // Register 0 is the constant ID word; it never depends on reset or writes.
  assign reg_q = {regs_r, IdValue};

  // When entering ACCESS straight from IDLE (no wait states) the latches are
  // not loaded yet, so decode the live bus; otherwise use the latched values.
  assign cur_addr_s  = (state_r == IDLE) ? p_addr  : addr_r;
  assign cur_write_s = (state_r == IDLE) ? p_write : write_r;
  assign cur_idx_s   = cur_addr_s[2 +: IdxW];
  assign cur_valid_s = (cur_addr_s[1:0] == 2'b00) &&
                       ((cur_addr_s >> (IdxW + 2)) == 32'd0);
  assign cur_err_s   = !cur_valid_s ||
                       (cur_write_s && (cur_idx_s == {IdxW{1'b0}}));
  assign rd_word_s   = reg_q[{cur_idx_s, 5'd0} +: 32];

  assign wr_idx_s       = addr_r[2 +: IdxW];
  assign enter_access_s = (next_state_s == ACCESS);
  // p_slverr is high only in ACCESS, so it doubles as the error flag here.
  assign commit_s       = (state_r == ACCESS) && p_sel && write_r && !p_slverr;

  // Next-state decode; an abort (p_sel low) in WAIT falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    setup_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (p_sel && !p_enable) begin
          setup_s      = 1'b1;
          next_state_s = NoWait ? ACCESS : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (!p_sel) begin
          next_state_s = IDLE;
        end else if (cnt_r == 4'd1) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = WAIT;
        end
      end
      ACCESS: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register, wait counter and setup-phase latches.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      write_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (setup_s) begin
        cnt_r   <= WaitLoad;
        addr_r  <= p_addr;
        wdata_r <= p_wdata;
        write_r <= p_write;
      end else if (next_state_s == WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
    end
  end

  // Response outputs are loaded on entry to ACCESS and cleared otherwise.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      p_ready  <= 1'b0;
      p_slverr <= 1'b0;
      p_rdata  <= 32'd0;
      wr_pulse <= {NumRegs{1'b0}};
    end else begin
      p_ready  <= enter_access_s;
      p_slverr <= enter_access_s && cur_err_s;
      p_rdata  <= (enter_access_s && !cur_err_s && !cur_write_s) ? rd_word_s : 32'd0;
      wr_pulse <= commit_s ? (OneHot0 << wr_idx_s) : {NumRegs{1'b0}};
    end
  end

  // Read/write register file; a write lands at the edge that ends ACCESS.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      regs_r <= '0;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        if (commit_s && (wr_idx_s == IdxW'(i))) begin
          regs_r[i] <= wdata_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: three instances (WaitStates 1, 0, 3)
// driven one at a time with directed and random APB transfers, compared
// against a per-instance register model.
module tb_apb_reg_slave;

  localparam int          NREGS = 8;
  localparam int          NDUT  = 3;
  localparam logic [31:0] ID    = 32'hA9B0_0001;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   a_reset;
  logic [31:0]            p_addr   [NDUT];
  logic                   p_sel    [NDUT];
  logic                   p_enable [NDUT];
  logic                   p_write  [NDUT];
  logic [31:0]            p_wdata  [NDUT];
  logic [31:0]            p_rdata  [NDUT];
  logic                   p_ready  [NDUT];
  logic                   p_slverr [NDUT];
  logic [NREGS*32-1:0]    reg_q    [NDUT];
  logic [NREGS-1:0]       wr_pulse [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_reg_slave #(.NumRegs(NREGS), .WaitStates(ws_of(g))) u_dut (
      .a_clk    (clk),
      .a_reset  (a_reset),
      .p_addr   (p_addr[g]),
      .p_sel    (p_sel[g]),
      .p_enable (p_enable[g]),
      .p_write  (p_write[g]),
      .p_wdata  (p_wdata[g]),
      .p_rdata  (p_rdata[g]),
      .p_ready  (p_ready[g]),
      .p_slverr (p_slverr[g]),
      .reg_q    (reg_q[g]),
      .wr_pulse (wr_pulse[g])
    );
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl [NDUT][NREGS];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [NREGS*32-1:0] exp_q(input int k);
    logic [NREGS*32-1:0] q;
    for (int i = 0; i < NREGS; i++) q[32*i +: 32] = (i == 0) ? ID : mdl[k][i];
    return q;
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < NREGS; i++) mdl[k][i] = 32'd0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return 32'(4 * $urandom_range(0, 7));
    else if (r == 7) return 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
    else if (r == 8) return 32'(4 * $urandom_range(8, 63));
    else             return $urandom | 32'h8000_0000;
  endfunction

  // One complete transfer on instance k; called and returns at a falling edge.
  task automatic xfer(input int k, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    int               idx;
    int               lat;
    logic             err;
    logic             rdy;
    logic             serr;
    logic [31:0]      rd;
    logic [31:0]      want_rd;
    logic [NREGS-1:0] want_pulse;
    idx        = 0;
    err        = (addr % 32'd4 != 32'd0) || (addr / 32'd4 >= 32'(NREGS)) || (wr && addr == 32'd0);
    if (!err) idx = int'(addr / 32'd4);
    want_rd    = 32'd0;
    want_pulse = '0;
    if (!err && !wr) want_rd = (idx == 0) ? ID : mdl[k][idx];
    if (!err && wr)  want_pulse = NREGS'(1) << idx;
    p_sel[k]    = 1'b1;
    p_enable[k] = 1'b0;
    p_addr[k]   = addr;
    p_write[k]  = wr;
    p_wdata[k]  = wdata;
    lat  = 0;
    rd   = 32'd0;
    serr = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      rdy  = p_ready[k];
      serr = p_slverr[k];
      rd   = p_rdata[k];
      // Bus lines other than p_sel/p_enable must be ignored after setup.
      p_enable[k] = 1'b1;
      p_addr[k]   = $urandom;
      p_wdata[k]  = $urandom;
      p_write[k]  = 1'($urandom);
      if (rdy) begin
        lat = c;
        break;
      end
      check($sformatf("k%0d wait_rdata", k), 256'(rd), 256'(0));
      check($sformatf("k%0d wait_slverr", k), 256'(serr), 256'(0));
    end
    check($sformatf("k%0d latency a=%0h", k, addr), 256'(lat), 256'(ws_of(k) + 1));
    check($sformatf("k%0d slverr a=%0h", k, addr), 256'(serr), 256'(err));
    check($sformatf("k%0d rdata a=%0h", k, addr), 256'(rd), 256'(want_rd));
    if (!err && wr) mdl[k][idx] = wdata;
    @(negedge clk);
    check($sformatf("k%0d wr_pulse a=%0h", k, addr), 256'(wr_pulse[k]), 256'(want_pulse));
    check($sformatf("k%0d reg_q", k), 256'(reg_q[k]), 256'(exp_q(k)));
    p_sel[k]    = 1'b0;
    p_enable[k] = 1'b0;
  endtask

  logic [NREGS*32-1:0] saved_q;

  initial begin
    a_reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      p_sel[k]    = 1'b0;
      p_enable[k] = 1'b0;
      p_write[k]  = 1'b0;
      p_addr[k]   = $urandom;
      p_wdata[k]  = $urandom;
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("k%0d rst_ready", k), 256'(p_ready[k]), 256'(0));
      check($sformatf("k%0d rst_slverr", k), 256'(p_slverr[k]), 256'(0));
      check($sformatf("k%0d rst_rdata", k), 256'(p_rdata[k]), 256'(0));
      check($sformatf("k%0d rst_pulse", k), 256'(wr_pulse[k]), 256'(0));
      check($sformatf("k%0d rst_q", k), 256'(reg_q[k]), 256'(exp_q(k)));
    end
    a_reset = 1'b0;
    @(negedge clk);

    // Directed write/read/error sequence on the one-wait-state instance.
    xfer(0, 32'h04, 1'b1, 32'hDEAD_BEEF);
    check("k0 reg1", 256'(reg_q[0][63:32]), 256'(32'hDEAD_BEEF));
    xfer(0, 32'h04, 1'b0, 32'd0);
    xfer(0, 32'h00, 1'b0, 32'd0);
    xfer(0, 32'h00, 1'b1, 32'h1234_5678);
    xfer(0, 32'h20, 1'b1, 32'h8765_4321);
    xfer(0, 32'h06, 1'b0, 32'd0);

    // Enable without a setup phase must not start a transfer.
    p_sel[0]    = 1'b1;
    p_enable[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("k0 no_setup_ready", 256'(p_ready[0]), 256'(0));
    end
    p_sel[0]    = 1'b0;
    p_enable[0] = 1'b0;
    @(negedge clk);
    check("k0 no_setup_ready2", 256'(p_ready[0]), 256'(0));

    // Back-to-back write then read with no wait states.
    xfer(1, 32'h08, 1'b1, 32'hCAFE_F00D);
    xfer(1, 32'h08, 1'b0, 32'd0);

    // Abort in WAIT on the three-wait-state instance.
    xfer(2, 32'h10, 1'b1, 32'h1111_2222);
    saved_q     = exp_q(2);
    p_sel[2]    = 1'b1;
    p_enable[2] = 1'b0;
    p_addr[2]   = 32'h10;
    p_write[2]  = 1'b1;
    p_wdata[2]  = 32'h5555_AAAA;
    @(negedge clk);
    check("k2 abort_ready0", 256'(p_ready[2]), 256'(0));
    p_sel[2]    = 1'b0;
    p_enable[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("k2 abort_ready", 256'(p_ready[2]), 256'(0));
      check("k2 abort_pulse", 256'(wr_pulse[2]), 256'(0));
    end
    check("k2 abort_q", 256'(reg_q[2]), 256'(saved_q));
    xfer(2, 32'h10, 1'b0, 32'd0);

    // Random traffic with random idle gaps (zero gap = back-to-back).
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        xfer(k, rand_addr(), 1'($urandom), $urandom);
      end
    end

    // Reset during WAIT of a write to register 3.
    xfer(0, 32'h0C, 1'b1, 32'h0BAD_F00D);
    p_sel[0]    = 1'b1;
    p_enable[0] = 1'b0;
    p_addr[0]   = 32'h0C;
    p_write[0]  = 1'b1;
    p_wdata[0]  = 32'h1234_5678;
    @(negedge clk);
    a_reset     = 1'b1;
    p_enable[0] = 1'b1;
    @(negedge clk);
    clear_model();
    check("k0 rstw_ready", 256'(p_ready[0]), 256'(0));
    check("k0 rstw_slverr", 256'(p_slverr[0]), 256'(0));
    check("k0 rstw_rdata", 256'(p_rdata[0]), 256'(0));
    check("k0 rstw_pulse", 256'(wr_pulse[0]), 256'(0));
    check("k0 rstw_q", 256'(reg_q[0]), 256'(exp_q(0)));
    a_reset     = 1'b0;
    p_sel[0]    = 1'b0;
    p_enable[0] = 1'b0;
    @(negedge clk);
    check("k0 rstw_pulse2", 256'(wr_pulse[0]), 256'(0));
    check("k0 rstw_reg3", 256'(reg_q[0][127:96]), 256'(0));
    xfer(0, 32'h0C, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
